item_table_ctrl: RTL

- Controller for the shop item table: owns up to MAX_ITEMS entries (name, stock, owner) and serialises ADD / DEL / BUY / CLEAR requests from the command FSM.
- Each request runs a fixed-length linear scan, then one update cycle.
- Returns a status code that the command FSM maps to its ASCII replies (ItmAdded, ItmExists, ItmsFull, NoStock, ...).

---
 rtl/item_table_ctrl.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/item_table_ctrl.sv
// Shop item table controller: serialises ADD/DEL/BUY/CLEAR requests with a
// fixed-length linear scan followed by a single update cycle.
module item_table_ctrl #(
    parameter int unsigned MAX_ITEMS  = 8,
    parameter int unsigned NAME_BITS  = 56,
    parameter int unsigned STOCK_BITS = 8,
    parameter int unsigned USER_BITS  = 4,
    parameter int unsigned COUNT_BITS = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic [1:0]            i_req_op,
    input  logic [NAME_BITS-1:0]  i_req_name,
    input  logic [STOCK_BITS-1:0] i_req_stock,
    input  logic [USER_BITS-1:0]  i_req_user,
    input  logic                  i_req_is_admin,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [3:0]            o_rsp_status,
    output logic [STOCK_BITS-1:0] o_rsp_stock,
    output logic [COUNT_BITS-1:0] o_item_count
);

    localparam int unsigned IDX_BITS = (MAX_ITEMS > 1) ? $clog2(MAX_ITEMS) : 1;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_DEL = 2'd1;
    localparam logic [1:0] OP_BUY = 2'd2;

    localparam logic [3:0] ST_ADDED     = 4'd0;
    localparam logic [3:0] ST_DELETED   = 4'd1;
    localparam logic [3:0] ST_BOUGHT    = 4'd2;
    localparam logic [3:0] ST_FULL      = 4'd3;
    localparam logic [3:0] ST_EXISTS    = 4'd4;
    localparam logic [3:0] ST_UNKNOWN   = 4'd5;
    localparam logic [3:0] ST_NOT_YOURS = 4'd6;
    localparam logic [3:0] ST_NO_STOCK  = 4'd7;
    localparam logic [3:0] ST_NO_PERM   = 4'd8;
    localparam logic [3:0] ST_CLEARED   = 4'd9;
    localparam logic [3:0] ST_BAD_NAME  = 4'd10;

    typedef enum logic [1:0] {IDLE, SCAN, EXEC, RESP} state_t;

    state_t                 state_q, state_d;
    logic [IDX_BITS-1:0]    idx_q, idx_d;
    logic [1:0]             op_q, op_d;
    logic [NAME_BITS-1:0]   rname_q, rname_d;
    logic [STOCK_BITS-1:0]  rstock_q, rstock_d;
    logic [USER_BITS-1:0]   ruser_q, ruser_d;
    logic                   radmin_q, radmin_d;
    logic                   hit_q, hit_d;
    logic [IDX_BITS-1:0]    hit_idx_q, hit_idx_d;
    logic                   free_q, free_d;
    logic [IDX_BITS-1:0]    free_idx_q, free_idx_d;
    logic [3:0]             status_q, status_d;
    logic [STOCK_BITS-1:0]  rsp_stock_q, rsp_stock_d;
    logic [COUNT_BITS-1:0]  count_q, count_d;
    logic                   ready_q, rsp_valid_q;

    logic                   tbl_wr, tbl_del, tbl_buy, tbl_clr;

    logic [MAX_ITEMS-1:0]   valid_q;
    logic [NAME_BITS-1:0]   name_q  [MAX_ITEMS];
    logic [STOCK_BITS-1:0]  stock_q [MAX_ITEMS];
    logic [USER_BITS-1:0]   owner_q [MAX_ITEMS];

    assign o_req_ready  = ready_q;
    assign o_rsp_valid  = rsp_valid_q;
    assign o_rsp_status = status_q;
    assign o_rsp_stock  = rsp_stock_q;
    assign o_item_count = count_q;

    // Control state, latched request and response registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            op_q        <= '0;
            rname_q     <= '0;
            rstock_q    <= '0;
            ruser_q     <= '0;
            radmin_q    <= 1'b0;
            hit_q       <= 1'b0;
            hit_idx_q   <= '0;
            free_q      <= 1'b0;
            free_idx_q  <= '0;
            status_q    <= '0;
            rsp_stock_q <= '0;
            count_q     <= '0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            op_q        <= op_d;
            rname_q     <= rname_d;
            rstock_q    <= rstock_d;
            ruser_q     <= ruser_d;
            radmin_q    <= radmin_d;
            hit_q       <= hit_d;
            hit_idx_q   <= hit_idx_d;
            free_q      <= free_d;
            free_idx_q  <= free_idx_d;
            status_q    <= status_d;
            rsp_stock_q <= rsp_stock_d;
            count_q     <= count_d;
            ready_q     <= (state_d == IDLE);
            rsp_valid_q <= (state_d == RESP);
        end
    end

    // Next-state, scan bookkeeping and EXEC decision logic.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        op_d        = op_q;
        rname_d     = rname_q;
        rstock_d    = rstock_q;
        ruser_d     = ruser_q;
        radmin_d    = radmin_q;
        hit_d       = hit_q;
        hit_idx_d   = hit_idx_q;
        free_d      = free_q;
        free_idx_d  = free_idx_q;
        status_d    = status_q;
        rsp_stock_d = rsp_stock_q;
        count_d     = count_q;
        tbl_wr      = 1'b0;
        tbl_del     = 1'b0;
        tbl_buy     = 1'b0;
        tbl_clr     = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_req_valid) begin
                    op_d       = i_req_op;
                    rname_d    = i_req_name;
                    rstock_d   = i_req_stock;
                    ruser_d    = i_req_user;
                    radmin_d   = i_req_is_admin;
                    idx_d      = '0;
                    hit_d      = 1'b0;
                    hit_idx_d  = '0;
                    free_d     = 1'b0;
                    free_idx_d = '0;
                    state_d    = SCAN;
                end
            end
            SCAN: begin
                if (valid_q[idx_q] && (name_q[idx_q] == rname_q)) begin
                    hit_d     = 1'b1;
                    hit_idx_d = idx_q;
                end
                if (!valid_q[idx_q] && !free_q) begin
                    free_d     = 1'b1;
                    free_idx_d = idx_q;
                end
                if (idx_q == IDX_BITS'(MAX_ITEMS - 1)) begin
                    state_d = EXEC;
                end else begin
                    idx_d = idx_q + IDX_BITS'(1);
                end
            end
            EXEC: begin
                state_d     = RESP;
                rsp_stock_d = '0;
                if ((rname_q == '0) && (op_q != 2'd3)) begin
                    status_d = ST_BAD_NAME;
                end else if (op_q == OP_ADD) begin
                    if (hit_q) begin
                        status_d    = ST_EXISTS;
                        rsp_stock_d = stock_q[hit_idx_q];
                    end else if (!free_q) begin
                        status_d = ST_FULL;
                    end else begin
                        tbl_wr      = 1'b1;
                        count_d     = count_q + COUNT_BITS'(1);
                        status_d    = ST_ADDED;
                        rsp_stock_d = rstock_q;
                    end
                end else if (op_q == OP_DEL) begin
                    if (!hit_q) begin
                        status_d = ST_UNKNOWN;
                    end else if ((owner_q[hit_idx_q] != ruser_q) && !radmin_q) begin
                        status_d = ST_NOT_YOURS;
                    end else begin
                        tbl_del     = 1'b1;
                        count_d     = count_q - COUNT_BITS'(1);
                        status_d    = ST_DELETED;
                        rsp_stock_d = stock_q[hit_idx_q];
                    end
                end else if (op_q == OP_BUY) begin
                    if (!hit_q) begin
                        status_d = ST_UNKNOWN;
                    end else if (stock_q[hit_idx_q] == '0) begin
                        status_d = ST_NO_STOCK;
                    end else begin
                        tbl_buy     = 1'b1;
                        status_d    = ST_BOUGHT;
                        rsp_stock_d = stock_q[hit_idx_q] - STOCK_BITS'(1);
                    end
                end else begin
                    if (!radmin_q) begin
                        status_d = ST_NO_PERM;
                    end else begin
                        tbl_clr  = 1'b1;
                        count_d  = '0;
                        status_d = ST_CLEARED;
                    end
                end
            end
            RESP: begin
                if (i_rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Entry valid bits; cleared by reset and CLEAR.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            valid_q <= '0;
        end else if (tbl_clr) begin
            valid_q <= '0;
        end else if (tbl_wr) begin
            valid_q[free_idx_q] <= 1'b1;
        end else if (tbl_del) begin
            valid_q[hit_idx_q] <= 1'b0;
        end
    end

    // Entry payload; only meaningful where the valid bit is set.
    always_ff @(posedge i_clk) begin
        if (tbl_wr) begin
            name_q[free_idx_q]  <= rname_q;
            stock_q[free_idx_q] <= rstock_q;
            owner_q[free_idx_q] <= ruser_q;
        end else if (tbl_buy) begin
            stock_q[hit_idx_q] <= stock_q[hit_idx_q] - STOCK_BITS'(1);
        end
    end

endmodule
